ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
Fetch sequencer that drives the instruction fetch path. It owns the program counter and issues single-outstanding requests to instruction memory with a req/gnt/rvalid handshake. Returned words are buffered in a small instruction queue that presents a valid/ready stream to decode. Branch redirects flush the queue and restart fetch.

Parameters:
AW, 16, address/PC width
DW, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 1, PC increment per fetch (word addressing)
QDEPTH, 2, instruction queue entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
en  input  1  fetch enable
mem_req  output  1  request valid to instruction memory
mem_addr  output  AW  request address; stable while mem_req=1 and mem_gnt=0
mem_gnt  input  1  memory accepts request this cycle
mem_rvalid  input  1  response data valid; never earlier than the cycle after mem_gnt
mem_rdata  input  DW  response instruction
redirect  input  1  branch/jump redirect, single-cycle pulse
redirect_pc  input  AW  redirect target
instr_valid  output  1  queue head valid
instr  output  DW  queue head instruction
instr_pc  output  AW  address of queue head
instr_ready  input  1  decode accepts head
pc  output  AW  next fetch address

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, queue empty, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, drop flag=0.
- FSM states: IDLE, REQ, WAIT, DRAIN. mem_req=1 only in REQ; mem_addr=pc.
- IDLE -> REQ when en=1 and free slots (QDEPTH - count) > 0. mem_req therefore rises the cycle after en is first sampled high.
- REQ: hold mem_req and mem_addr until mem_gnt. On gnt: latch req_pc=pc, pc<=pc+PC_INC (wraps modulo 2^AW), go to WAIT.
- WAIT: on mem_rvalid, push {req_pc, mem_rdata} into the queue. Next state:
  - REQ if en=1 and the queue has a free slot after this cycle's push/pop;
  - otherwise IDLE.
- Queue: instr_valid = count!=0. Outputs are the head entry, registered, so a pushed word appears on instr_valid the cycle after mem_rvalid. Pop on instr_valid&instr_ready. Simultaneous push and pop keeps count unchanged. A push never targets a full queue, because an issue requires a reserved slot.
- Redirect (highest priority):
  - Queue is flushed and pc<=redirect_pc.
  - A pop in the same cycle still counts as consumed.
  - In IDLE or REQ without gnt: mem_req drops, next state is REQ if en=1, else IDLE.
  - In REQ with gnt the same cycle, or in WAIT without rvalid: the request is outstanding, so go to DRAIN.
  - In WAIT with rvalid the same cycle: discard the data, go to REQ/IDLE.
- DRAIN: mem_req=0. On mem_rvalid, discard the data (no push), then go to REQ if en=1, else IDLE. A redirect while in DRAIN updates pc and stays in DRAIN.
- en=0: no new requests. An outstanding response is still accepted and pushed, then the FSM goes to IDLE. The queue contents are retained.
- Reset mid-transaction: everything clears immediately. Any later mem_rvalid seen in IDLE is ignored.

Optional Feature:
IFU_PERF_EN:
- Defined: adds outputs perf_fetch (16b, responses pushed), perf_stall (16b, cycles with instr_valid=1 and instr_ready=0) and perf_flush (16b, redirects).
  - All three counters saturate at 16'hFFFF.
  - All three reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then en=1, instruction memory returns addr+16'h1000 one cycle after each gnt, gnt same cycle as req, instr_ready=1 -> instr_pc sequence 0,1,2,3 with instr 1000,1001,1002,1003; mem_req first high 1 cycle after en.
- instr_ready=0 held -> exactly QDEPTH=2 entries (pc 0,1) fetched, mem_req stays 0; release ready -> fetch resumes at pc=2; perf_stall counts held cycles when IFU_PERF_EN.
- Redirect to 16'h0040 while in WAIT -> late response dropped (never on instr), queue empty, next mem_addr=0040, first instr_pc=0040.
- Redirect in the same cycle as mem_rvalid, and separately in the same cycle as mem_gnt -> no stale instruction is delivered in either case; next request addr equals redirect_pc.
- mem_gnt delayed 3 cycles -> mem_addr constant throughout; pc=16'hFFFF fetch -> next pc wraps to 0000.
- Assert rst low while in WAIT -> all outputs return to reset values asynchronously; a trailing mem_rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding memory request at a time,
// and buffers returned words in a small queue for decode. Optional counters under IFU_PERF_EN.
module ifu_fetch_ctrl #(
    parameter int             AW       = 16,
    parameter int             DW       = 16,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int             PC_INC   = 1,
    parameter int             QDEPTH   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    output logic [AW-1:0] pc
`ifdef IFU_PERF_EN
    ,
    output logic [15:0]   perf_fetch,
    output logic [15:0]   perf_stall,
    output logic [15:0]   perf_flush
`endif
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state, state_next;
    logic [AW-1:0] pc_q, req_pc;
    logic [DW-1:0] q_data [QDEPTH];
    logic [AW-1:0] q_pc   [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;
    logic          push, pop, gnt_taken;

    assign mem_req     = (state == REQ);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_valid = (count != '0);
    assign instr       = q_data[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];

    assign pop       = instr_valid && instr_ready;
    assign push      = (state == WAIT) && mem_rvalid && !redirect;
    assign gnt_taken = (state == REQ) && mem_gnt;

    always_comb begin
        count_next = count;
        if (redirect)
            count_next = '0;
        else if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    // A request is only issued when a queue slot is reserved for its response.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (redirect)
                    state_next = en ? REQ : IDLE;
                else if (en && (count < CW'(QDEPTH)))
                    state_next = REQ;
            end
            REQ: begin
                if (redirect)
                    state_next = mem_gnt ? DRAIN : (en ? REQ : IDLE);
                else if (mem_gnt)
                    state_next = WAIT;
            end
            WAIT: begin
                if (mem_rvalid)
                    state_next = (en && (count_next < CW'(QDEPTH))) ? REQ : IDLE;
                else if (redirect)
                    state_next = DRAIN;
            end
            default: begin
                // The outstanding response completes the drain even if another redirect lands on it.
                if (mem_rvalid)
                    state_next = en ? REQ : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            req_pc <= '0;
        end else begin
            state <= state_next;
            if (redirect)
                pc_q <= redirect_pc;
            else if (gnt_taken)
                pc_q <= pc_q + AW'(PC_INC);
            if (gnt_taken)
                req_pc <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            count <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    q_data[wr_ptr] <= mem_rdata;
                    q_pc[wr_ptr]   <= req_pc;
                    wr_ptr         <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch <= '0;
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (push && (perf_fetch != 16'hFFFF))
                perf_fetch <= perf_fetch + 1'b1;
            if (instr_valid && !instr_ready && (perf_stall != 16'hFFFF))
                perf_stall <= perf_stall + 1'b1;
            if (redirect && (perf_flush != 16'hFFFF))
                perf_flush <= perf_flush + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: a small instruction-memory model answers addr+0x1000
// one cycle after each grant, and a monitor logs every instruction handed to decode.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [15:0] pc;
`ifdef IFU_PERF_EN
    logic [15:0] perf_fetch, perf_stall, perf_flush;
`endif

    logic        auto_mem = 1'b0;
    int          gnt_delay = 0;
    logic        man_gnt = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [15:0] man_rdata = '0;
    logic        resp_pend = 1'b0;
    logic [15:0] resp_addr = '0;
    int          req_wait = 0;

    logic [31:0] log_q [$];
    int          total_checks = 0;
    int          passed_checks = 0;
    int          failed_checks = 0;
    int          base;

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .pc          (pc)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    // Memory model: grant after gnt_delay waiting cycles, respond exactly one cycle after grant.
    always_ff @(posedge clk) begin
        if (auto_mem && mem_req && mem_gnt) begin
            resp_pend <= 1'b1;
            resp_addr <= mem_addr;
        end else begin
            resp_pend <= 1'b0;
        end
        if (mem_req && !mem_gnt)
            req_wait <= req_wait + 1;
        else
            req_wait <= 0;
    end

    assign mem_gnt    = auto_mem ? (mem_req && (req_wait >= gnt_delay)) : man_gnt;
    assign mem_rvalid = auto_mem ? resp_pend : man_rvalid;
    assign mem_rdata  = auto_mem ? (resp_addr + 16'h1000) : man_rdata;

    always @(posedge clk) begin
        if (rst && instr_valid && instr_ready)
            log_q.push_back({instr_pc, instr});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check_output("wait_log", 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        en         = 1'b0;
        redirect   = 1'b0;
        auto_mem   = 1'b0;
        man_gnt    = 1'b0;
        man_rvalid = 1'b0;
        gnt_delay  = 0;
        rst        = 1'b0;
        tick(2);
        rst        = 1'b1;
        base       = log_q.size();
    endtask

    initial begin
        #2 rst = 1'b0;
        tick(2);
        $display("[TB] reset values");
        check_output("rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rst_mem_addr", 32'(mem_addr), 32'h0000);
        check_output("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_output("rst_instr", 32'(instr), 32'h0000);
        check_output("rst_instr_pc", 32'(instr_pc), 32'h0000);
        check_output("rst_pc", 32'(pc), 32'h0000);

        $display("[TB] streaming fetch");
        rst = 1'b1;
        base = log_q.size();
        auto_mem = 1'b1;
        instr_ready = 1'b1;
        en = 1'b1;
        check_output("req_before_en_sampled", 32'(mem_req), 32'd0);
        tick(1);
        check_output("req_one_cycle_after_en", 32'(mem_req), 32'd1);
        check_output("first_addr", 32'(mem_addr), 32'h0000);
        wait_log(base + 4, 40);
        check_output("stream_0", log_q[base], 32'h0000_1000);
        check_output("stream_1", log_q[base + 1], 32'h0001_1001);
        check_output("stream_2", log_q[base + 2], 32'h0002_1002);
        check_output("stream_3", log_q[base + 3], 32'h0003_1003);

        $display("[TB] decode stall fills queue");
        do_reset();
        auto_mem = 1'b1;
        instr_ready = 1'b0;
        en = 1'b1;
        tick(20);
        check_output("stall_mem_req", 32'(mem_req), 32'd0);
        check_output("stall_pc", 32'(pc), 32'h0002);
        check_output("stall_head", {instr_pc, instr}, 32'h0000_1000);
        check_output("stall_valid", 32'(instr_valid), 32'd1);
`ifdef IFU_PERF_EN
        check_output("perf_fetch", 32'(perf_fetch), 32'd2);
        check_output("perf_stall", 32'(perf_stall), 32'd17);
`endif
        instr_ready = 1'b1;
        wait_log(base + 3, 40);
        check_output("resume_0", log_q[base], 32'h0000_1000);
        check_output("resume_1", log_q[base + 1], 32'h0001_1001);
        check_output("resume_2", log_q[base + 2], 32'h0002_1002);

        $display("[TB] redirect while waiting");
        do_reset();
        instr_ready = 1'b1;
        en = 1'b1;
        tick(1);
        check_output("w_req", 32'(mem_req), 32'd1);
        man_gnt = 1'b1;
        tick(1);
        man_gnt = 1'b0;
        check_output("w_pc_after_gnt", 32'(pc), 32'h0001);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick(1);
        redirect = 1'b0;
        check_output("w_drain_req", 32'(mem_req), 32'd0);
        check_output("w_drain_pc", 32'(pc), 32'h0040);
`ifdef IFU_PERF_EN
        check_output("perf_flush", 32'(perf_flush), 32'd1);
`endif
        man_rvalid = 1'b1;
        man_rdata = 16'hDEAD;
        tick(1);
        man_rvalid = 1'b0;
        check_output("w_dropped_valid", 32'(instr_valid), 32'd0);
        check_output("w_next_req", 32'(mem_req), 32'd1);
        check_output("w_next_addr", 32'(mem_addr), 32'h0040);
        auto_mem = 1'b1;
        wait_log(base + 1, 20);
        check_output("w_first_instr", log_q[base], 32'h0040_1040);

        $display("[TB] redirect with rvalid, then with gnt");
        do_reset();
        instr_ready = 1'b1;
        en = 1'b1;
        tick(1);
        man_gnt = 1'b1;
        tick(1);
        man_gnt = 1'b0;
        man_rvalid = 1'b1;
        man_rdata = 16'hBEEF;
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        tick(1);
        man_rvalid = 1'b0;
        redirect = 1'b0;
        check_output("rv_req", 32'(mem_req), 32'd1);
        check_output("rv_addr", 32'(mem_addr), 32'h0080);
        check_output("rv_valid", 32'(instr_valid), 32'd0);
        tick(2);
        check_output("rv_no_stale", 32'(log_q.size()), 32'(base));
        man_gnt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h00C0;
        tick(1);
        man_gnt = 1'b0;
        redirect = 1'b0;
        check_output("gnt_drain_req", 32'(mem_req), 32'd0);
        check_output("gnt_pc", 32'(pc), 32'h00C0);
        man_rvalid = 1'b1;
        man_rdata = 16'h0BAD;
        tick(1);
        man_rvalid = 1'b0;
        check_output("gnt_valid", 32'(instr_valid), 32'd0);
        check_output("gnt_next_addr", 32'(mem_addr), 32'h00C0);
        auto_mem = 1'b1;
        wait_log(base + 1, 20);
        check_output("gnt_first_instr", log_q[base], 32'h00C0_10C0);

        $display("[TB] delayed grant and pc wrap");
        do_reset();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'hFFFF;
        tick(1);
        redirect = 1'b0;
        check_output("wrap_pc_loaded", 32'(pc), 32'h0000_FFFF);
        auto_mem = 1'b1;
        gnt_delay = 3;
        en = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            check_output("held_addr", 32'(mem_addr), 32'h0000_FFFF);
            check_output("held_no_gnt", 32'(mem_gnt), 32'd0);
            tick(1);
        end
        check_output("late_gnt", 32'(mem_gnt), 32'd1);
        check_output("late_addr", 32'(mem_addr), 32'h0000_FFFF);
        en = 1'b0;
        tick(1);
        check_output("wrap_pc", 32'(pc), 32'h0000);
        wait_log(base + 1, 20);
        check_output("wrap_instr", log_q[base], 32'hFFFF_0FFF);
        gnt_delay = 0;

        $display("[TB] reset during wait");
        do_reset();
        auto_mem = 1'b1;
        instr_ready = 1'b1;
        en = 1'b1;
        tick(2);
        check_output("mid_pc", 32'(pc), 32'h0001);
        rst = 1'b0;
        #1;
        check_output("async_mem_req", 32'(mem_req), 32'd0);
        check_output("async_pc", 32'(pc), 32'h0000);
        check_output("async_mem_addr", 32'(mem_addr), 32'h0000);
        check_output("async_valid", 32'(instr_valid), 32'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("trail_ignored", 32'(instr_valid), 32'd0);
        check_output("restart_req", 32'(mem_req), 32'd1);
        check_output("restart_addr", 32'(mem_addr), 32'h0000);
        wait_log(base + 1, 20);
        check_output("restart_instr", log_q[base], 32'h0000_1000);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
